// File: rtl/sobel_stream_pkg.sv
// Shared constants and types for the streaming Sobel edge detector.
package sobel_stream_pkg;

  localparam int unsigned DEF_IMG_W  = 640;
  localparam int unsigned DEF_IMG_H  = 480;
  localparam int unsigned GRAD_EXTRA = 3;

  // Signed gradient width: 4*max pixel plus sign fits in PIX_W+3 bits.
  function automatic int unsigned grad_w(input int unsigned pix_w);
    return pix_w + GRAD_EXTRA;
  endfunction

  function automatic int unsigned sat_max(input int unsigned pix_w);
    return (32'd1 << pix_w) - 32'd1;
  endfunction

  // Per-pixel side information carried alongside the data through the pipe.
  typedef struct packed {
    logic sof;
    logic eol;
    logic thr_en;
  } tag_t;

endpackage

// File: rtl/sobel_linebuf.sv
// DEPTH-deep single-port delay line; dout is the sample written DEPTH shifts ago.
module sobel_linebuf
  import sobel_stream_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned DEPTH = DEF_IMG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Read-before-write at the same address gives an exact DEPTH-sample delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (shift) mem[ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (shift) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: window, gradient and output stages
// share one advance enable so backpressure stalls the whole pipe.
module sobel_stream
  import sobel_stream_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  input  logic             thr_en,
  input  logic [PIX_W-1:0] thr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sof,
  output logic             out_eol
);

  localparam int unsigned GW = grad_w(PIX_W);
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [GW-1:0] SAT = GW'(sat_max(PIX_W));

  logic en;
  logic xfer;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign xfer     = in_valid && en;

  // Raster position of the pixel being offered; in_sof forces (0,0).
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;

  always_comb begin
    cur_col = in_sof ? '0 : col;
    cur_row = in_sof ? '0 : row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  logic [PIX_W-1:0] lb0_out, lb1_out;

  sobel_linebuf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .rst   (rst),
    .shift (xfer),
    .din   (in_pix),
    .dout  (lb0_out)
  );

  sobel_linebuf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .rst   (rst),
    .shift (xfer),
    .din   (lb0_out),
    .dout  (lb1_out)
  );

  // 3x3 window, raster order: win[0..2] row r-2, win[3..5] r-1, win[6..8] r.
  logic [PIX_W-1:0] win [9];

  always_ff @(posedge clk) begin
    if (xfer) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb1_out;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb0_out;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= in_pix;
    end
  end

  // Stage 1: window valid and side information.
  logic             s1_valid;
  tag_t             s1_tag;
  logic [PIX_W-1:0] s1_thr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= xfer && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_tag.sof    <= (cur_row == RW'(2)) && (cur_col == CW'(2));
      s1_tag.eol    <= (cur_col == CW'(IMG_W - 1));
      s1_tag.thr_en <= thr_en;
      s1_thr        <= thr;
    end
  end

  // Stage 2: signed gradients.
  logic signed [GW-1:0] w [9];
  logic signed [GW-1:0] gx_c, gy_c;

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w[i] = $signed(GW'(win[i]));
    end
    gx_c = (w[2] + (w[5] <<< 1) + w[8]) - (w[0] + (w[3] <<< 1) + w[6]);
    gy_c = (w[0] + (w[1] <<< 1) + w[2]) - (w[6] + (w[7] <<< 1) + w[8]);
  end

  logic                 s2_valid;
  tag_t                 s2_tag;
  logic [PIX_W-1:0]     s2_thr;
  logic signed [GW-1:0] s2_gx, s2_gy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s2_tag <= s1_tag;
      s2_thr <= s1_thr;
      s2_gx  <= gx_c;
      s2_gy  <= gy_c;
    end
  end

  // Stage 3: magnitude, saturation and optional threshold.
  logic [GW-1:0]    abs_gx, abs_gy, mag;
  logic [PIX_W-1:0] sat_pix, res_pix;

  always_comb begin
    abs_gx  = s2_gx[GW-1] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
    abs_gy  = s2_gy[GW-1] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
    mag     = abs_gx + abs_gy;
    sat_pix = (mag > SAT) ? PIX_W'(SAT) : mag[PIX_W-1:0];
    res_pix = sat_pix;
    if (s2_tag.thr_en) begin
      res_pix = (sat_pix >= s2_thr) ? '1 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_pix   <= res_pix;
      out_sof   <= s2_valid && s2_tag.sof;
      out_eol   <= s2_valid && s2_tag.eol;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: directed frame table, latency/reset/resync sequences
// and randomized backpressure against an image-array reference model.
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N_OUT = (W - 2) * (H - 2);

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pix;
  logic       in_sof;
  logic       thr_en;
  logic [7:0] thr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pix;
  logic       out_sof;
  logic       out_eol;

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_sof    (in_sof),
    .thr_en    (thr_en),
    .thr       (thr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] pix; logic sof; logic eol; } out_t;
  typedef struct { logic [7:0] pix; logic sof; logic eol; int cyc; } cap_t;
  typedef struct { int pat; logic ten; logic [7:0] th; logic [7:0] cmask; logic [7:0] hi; logic [7:0] lo; } vec_t;

  out_t exp_q[$];
  cap_t cap_q[$];
  int   tests = 0;
  int   fails = 0;
  int   img [H][W];
  int   mr = 0;
  int   mc = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  bit   gaps = 0;
  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: keep the frame as an image and apply the Sobel sums directly.
  function automatic void model_push(input int pix, input logic sof, input logic ten, input int th);
    int gx, gy, mag, o;
    out_t e;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      gx = (img[mr-2][mc] + 2*img[mr-1][mc] + img[mr][mc])
         - (img[mr-2][mc-2] + 2*img[mr-1][mc-2] + img[mr][mc-2]);
      gy = (img[mr-2][mc-2] + 2*img[mr-2][mc-1] + img[mr-2][mc])
         - (img[mr][mc-2] + 2*img[mr][mc-1] + img[mr][mc]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
      o = ten ? ((mag >= th) ? 255 : 0) : mag;
      e.pix = 8'(o);
      e.sof = (mr == 2 && mc == 2);
      e.eol = (mc == W - 1);
      exp_q.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor and backpressure rule, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_ready)       check("in_ready_free", int'(in_ready), 1);
      else if (out_valid)  check("in_ready_stall", int'(in_ready), 0);
      else                 check("in_ready_idle", int'(in_ready), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          out_t e;
          e = exp_q.pop_front();
          check("out_pix", int'(out_pix), int'(e.pix));
          check("out_sof", int'(out_sof), int'(e.sof));
          check("out_eol", int'(out_eol), int'(e.eol));
        end
        cap_q.push_back('{out_pix, out_sof, out_eol, cyc});
      end
    end
  end

  function automatic logic [7:0] pat_pix(input int p, input int c);
    case (p)
      0:       return 8'd100;
      1:       return (c < 4) ? 8'd0 : 8'd255;
      2:       return 8'(10 * c);
      default: return 8'($urandom_range(255, 0));
    endcase
  endfunction

  task automatic send(input logic [7:0] pix, input logic sof, input logic ten, input logic [7:0] th);
    int waited;
    if (gaps && ($urandom % 2 == 1)) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_pix   = pix;
    in_sof   = sof;
    thr_en   = ten;
    thr      = th;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      model_push(int'(pix), sof, ten, int'(th));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int p, input logic ten, input logic [7:0] th);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (p == 3) send(pat_pix(p, c), r == 0 && c == 0, 1'($urandom % 2), 8'($urandom));
        else        send(pat_pix(p, c), r == 0 && c == 0, ten, th);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_cap(input int n, input string name);
    int k;
    k = 0;
    while (cap_q.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, cap_q.size(), n);
  endtask

  task automatic drain_exp(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Compare a captured frame against a directed-table expectation.
  task automatic check_frame(input vec_t v, input bit span);
    int c;
    logic [7:0] m;
    m = v.cmask;
    if (cap_q.size() >= N_OUT) begin
      for (int i = 0; i < N_OUT; i++) begin
        c = (i % (W - 2)) + 1;
        check("tbl_pix", int'(cap_q[i].pix), m[c] ? int'(v.hi) : int'(v.lo));
        check("tbl_sof", int'(cap_q[i].sof), (i == 0) ? 1 : 0);
        check("tbl_eol", int'(cap_q[i].eol), (i % (W - 2) == W - 3) ? 1 : 0);
      end
      if (span) check("throughput_span", cap_q[N_OUT-1].cyc - cap_q[0].cyc, (H - 3) * W + (W - 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1'b0, 8'd0,   8'h00,        8'd255, 8'd0};
    tbl[1] = '{1, 1'b0, 8'd0,   8'b0001_1000, 8'd255, 8'd0};
    tbl[2] = '{2, 1'b1, 8'd80,  8'hFF,        8'd255, 8'd0};
    tbl[3] = '{2, 1'b1, 8'd81,  8'h00,        8'd255, 8'd0};
    tbl[4] = '{2, 1'b0, 8'd0,   8'hFF,        8'd80,  8'd0};
    tbl[5] = '{1, 1'b1, 8'd200, 8'b0001_1000, 8'd255, 8'd0};

    rst = 1'b0; in_valid = 1'b0; in_pix = '0; in_sof = 1'b0; thr_en = 1'b0; thr = '0;
    #2 rst = 1'b1;
    #20;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pix", int'(out_pix), 0);
    check("rst_out_sof", int'(out_sof), 0);
    check("rst_out_eol", int'(out_eol), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Latency: first complete window at edge E gives out_valid after E+2.
    for (int i = 0; i <= 2 * W + 2; i++) send(8'd100, i == 0, 1'b0, 8'd0);
    in_valid = 1'b0;
    @(negedge clk); check("lat_e0", int'(out_valid), 0);
    @(negedge clk); check("lat_e1", int'(out_valid), 0);
    @(negedge clk); check("lat_e2", int'(out_valid), 1);
    drain_exp("lat_drain");

    foreach (tbl[i]) begin
      cap_q.delete();
      send_frame(tbl[i].pat, tbl[i].ten, tbl[i].th);
      drain_cap(N_OUT, "tbl_count");
      check_frame(tbl[i], 1'b1);
    end

    // Randomized pixels, thresholds, input gaps and output backpressure.
    ready_mode = 1;
    gaps = 1'b1;
    repeat (4) send_frame(3, 1'b0, 8'd0);
    drain_exp("rand_drain");
    ready_mode = 0;
    gaps = 1'b0;

    // Reset mid-frame with a held output.
    for (int i = 0; i < 20; i++) send(pat_pix(3, i % W), i == 0, 1'b0, 8'd0);
    in_valid = 1'b0;
    ready_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", int'(out_valid), 0);
    check("rst_async_sof", int'(out_sof), 0);
    exp_q.delete();
    mr = 0; mc = 0;
    ready_mode = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    cap_q.delete();
    send_frame(0, 1'b0, 8'd0);
    drain_cap(N_OUT, "rst_frame_count");
    check_frame(tbl[0], 1'b0);

    // Resync: new frame starts at col 5 of row 3 of a partial frame.
    for (int i = 0; i < 3 * W + 5; i++) send(pat_pix(3, i % W), i == 0, 1'b0, 8'd0);
    in_valid = 1'b0;
    drain_exp("resync_pre_drain");
    cap_q.delete();
    send_frame(1, 1'b0, 8'd0);
    drain_cap(N_OUT, "resync_count");
    check_frame(tbl[1], 1'b0);
    send_frame(3, 1'b0, 8'd0);
    drain_exp("resync_rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
